// File: rtl/m65c02_microcycle_ctl_if.sv
// ---------------------------------------------------------------------------
// m65c02_microcycle_ctl_if
// Signals between the microcycle controller and its neighbours: the microword
// pipeline and memory interface (requests in), and the sequencer (Rdy out).
//   En    : global run enable
//   Len   : microcycle length minus 1 from the current microword
//   Wait  : memory wait request
//   Rdy   : microcycle complete, sequencer clock enable
//   Start : first clock of a microcycle
//   Cyc   : clock index within the microcycle
//   WS    : current clock is a wait state
//   BErr  : watchdog-forced completion pulse
// master = surrounding core logic, slave = the microcycle controller.
// ---------------------------------------------------------------------------
interface m65c02_microcycle_ctl_if;
    logic       En;
    logic [1:0] Len;
    logic       Wait;
    logic       Rdy;
    logic       Start;
    logic [1:0] Cyc;
    logic       WS;
    logic       BErr;

    modport master (
        output En, Len, Wait,
        input  Rdy, Start, Cyc, WS, BErr
    );

    modport slave (
        input  En, Len, Wait,
        output Rdy, Start, Cyc, WS, BErr
    );
endinterface

// File: rtl/m65c02_microcycle_ctl.sv
// ---------------------------------------------------------------------------
// m65c02_microcycle_ctl
// Generates Rdy, the microprogram sequencer clock enable, so that each
// microinstruction lasts Len+1 clocks, stretched by wait states while Wait is
// held on the last clock. A watchdog forces completion (with a one-clock BErr
// pulse) once pWaitMax consecutive wait states have elapsed.
// Ports:
//   Clk : module clock
//   Rst : asynchronous reset, active low
//   bus : slave side of m65c02_microcycle_ctl_if (En/Len/Wait in,
//         Rdy/Start/Cyc/WS/BErr out)
// Parameters:
//   pWaitMax   : wait states before forced completion (1..255)
//   pWCntWidth : wait counter width, 2**pWCntWidth > pWaitMax
// ---------------------------------------------------------------------------
module m65c02_microcycle_ctl #(
    parameter int pWaitMax   = 15,
    parameter int pWCntWidth = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    m65c02_microcycle_ctl_if.slave bus
);

    logic                  run_q, run_d;
    logic [1:0]            cyc_q, cyc_d;
    logic [1:0]            len_r_q, len_r_d;
    logic [pWCntWidth-1:0] wcnt_q, wcnt_d;

    logic       act;
    logic [1:0] len_eff;
    logic       last;
    logic       to;
    logic       rdy, start, ws, berr;

    always_comb begin
        act     = run_q & bus.En;
        // Len is only trusted on the first clock; LenR carries it afterwards.
        len_eff = (cyc_q == 2'd0) ? bus.Len : len_r_q;
        last    = (cyc_q == len_eff);
        to      = (wcnt_q == pWCntWidth'(pWaitMax));

        start = act & (cyc_q == 2'd0);
        rdy   = act & last & (~bus.Wait | to);
        ws    = act & last & bus.Wait & ~to;
        berr  = act & last & bus.Wait & to;

        // Run sets on the first edge after reset release, independent of En,
        // which delays the first Rdy by one clock to match the sequencer.
        run_d   = 1'b1;
        cyc_d   = cyc_q;
        len_r_d = len_r_q;
        wcnt_d  = wcnt_q;

        if (act) begin
            if (cyc_q == 2'd0)
                len_r_d = bus.Len;
            if (rdy) begin
                cyc_d  = 2'd0;
                wcnt_d = '0;
            end else if (ws) begin
                wcnt_d = wcnt_q + pWCntWidth'(1);
            end else begin
                cyc_d = cyc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            run_q   <= 1'b0;
            cyc_q   <= 2'd0;
            len_r_q <= 2'd0;
            wcnt_q  <= '0;
        end else begin
            run_q   <= run_d;
            cyc_q   <= cyc_d;
            len_r_q <= len_r_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.Rdy   = rdy;
    assign bus.Start = start;
    assign bus.WS    = ws;
    assign bus.BErr  = berr;
    // cyc_q is cleared by reset and cannot advance until Run is set, so it
    // already reads 0 whenever Rst=0 or Run=0.
    assign bus.Cyc   = cyc_q;

endmodule

// File: tb/tb_m65c02_microcycle_ctl.sv
// ---------------------------------------------------------------------------
// tb_m65c02_microcycle_ctl
// Per-clock expectations {Rdy,Start,Cyc[1:0],WS,BErr} are pushed to a queue
// as each clock's inputs are driven, then popped and compared at the falling
// edge of that clock.
// ---------------------------------------------------------------------------
module tb_m65c02_microcycle_ctl;

    logic Clk;
    logic Rst;

    m65c02_microcycle_ctl_if bus();

    m65c02_microcycle_ctl #(
        .pWaitMax   (15),
        .pWCntWidth (8)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    wire [5:0] obs = {bus.Rdy, bus.Start, bus.Cyc, bus.WS, bus.BErr};

    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Drive one clock's inputs just after the rising edge, queue the
    // expected outputs, and return at the falling edge of the same clock.
    task automatic drive(input logic rst, input logic en, input logic [1:0] len,
                         input logic wt, input logic [5:0] e);
        @(posedge Clk);
        #1;
        Rst      = rst;
        bus.En   = en;
        bus.Len  = len;
        bus.Wait = wt;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        logic [5:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'd0, 1'b0, 6'b000000);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL reset_hold clk %0d: got %b want %b", i, obs, e);
            else n_pass++;
        end
        // First clock after release: Run not yet set.
        drive(1'b1, 1'b1, 2'd0, 1'b0, 6'b000000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL reset_first_clk: got %b want %b", obs, e);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 2'd0, 1'b0, 6'b110000);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL reset_free_run clk %0d: got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_length(input logic [1:0] len);
        logic [5:0] e;
        logic [1:0] c;
        for (int i = 0; i < 2 * (int'(len) + 1); i++) begin
            c = 2'(i % (int'(len) + 1));
            drive(1'b1, 1'b1, len, 1'b0, {c == len, c == 2'd0, c, 1'b0, 1'b0});
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL len_sweep len %0d clk %0d: got %b want %b", len, i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_len_change();
        logic [5:0] e;
        logic [1:0] lens [4] = '{2'd2, 2'd0, 2'd0, 2'd0};
        logic [5:0] exps [4] = '{6'b010000, 6'b000100, 6'b101000, 6'b110000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, lens[i], 1'b0, exps[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL len_change clk %0d: got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_wait();
        logic [5:0] e;
        logic       waits [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0] exps  [7] = '{6'b010000, 6'b000110, 6'b000110, 6'b000110,
                                  6'b100100, 6'b010000, 6'b100100};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 2'd1, waits[i], exps[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL wait_states clk %0d: got %b want %b", i, obs, e);
            else n_pass++;
            if (i == 5) begin
                n_checks++;
                if (dut.wcnt_q !== 8'd0) $display("FAIL wcnt_cleared: got %0d want 0", dut.wcnt_q);
                else n_pass++;
            end
        end
    endtask

    task automatic test_watchdog();
        logic [5:0] e;
        int         n_ws;
        int         n_berr;
        for (int rep = 0; rep < 2; rep++) begin
            n_ws   = 0;
            n_berr = 0;
            for (int i = 0; i < 16; i++) begin
                drive(1'b1, 1'b1, 2'd0, 1'b1, (i < 15) ? 6'b010010 : 6'b110001);
                e = exp_q.pop_front();
                if (bus.WS === 1'b1)   n_ws++;
                if (bus.BErr === 1'b1) n_berr++;
                n_checks++;
                if (obs !== e) $display("FAIL watchdog rep %0d clk %0d: got %b want %b", rep, i, obs, e);
                else n_pass++;
            end
            n_checks++;
            if (n_ws != 15 || n_berr != 1)
                $display("FAIL watchdog_count rep %0d: got ws=%0d berr=%0d want ws=15 berr=1", rep, n_ws, n_berr);
            else n_pass++;
        end
        drive(1'b1, 1'b1, 2'd0, 1'b0, 6'b110000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL watchdog_exit: got %b want %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_en_freeze();
        logic [5:0] e;
        logic       ens  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] exps [8] = '{6'b010000, 6'b000100, 6'b001000, 6'b001000,
                                 6'b001000, 6'b001000, 6'b001000, 6'b101100};
        for (int i = 0; i < 8; i++) begin
            // Wait held high while frozen must not create wait states.
            drive(1'b1, ens[i], 2'd3, (i >= 2 && i <= 5), exps[i]);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) $display("FAIL en_freeze clk %0d: got %b want %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        drive(1'b1, 1'b1, 2'd1, 1'b0, 6'b010000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_pre0: got %b want %b", obs, e);
        else n_pass++;
        drive(1'b1, 1'b1, 2'd1, 1'b0, 6'b100100);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_pre1: got %b want %b", obs, e);
        else n_pass++;
        // Assert reset between edges; outputs must clear with no clock edge.
        #2;
        Rst = 1'b0;
        exp_q.push_back(6'b000000);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_immediate: got %b want %b", obs, e);
        else n_pass++;
        drive(1'b0, 1'b1, 2'd1, 1'b0, 6'b000000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_hold: got %b want %b", obs, e);
        else n_pass++;
        drive(1'b1, 1'b1, 2'd1, 1'b0, 6'b000000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_release: got %b want %b", obs, e);
        else n_pass++;
        drive(1'b1, 1'b1, 2'd1, 1'b0, 6'b010000);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_restart0: got %b want %b", obs, e);
        else n_pass++;
        drive(1'b1, 1'b1, 2'd1, 1'b0, 6'b100100);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL areset_restart1: got %b want %b", obs, e);
        else n_pass++;
    endtask

    initial begin
        Rst      = 1'b0;
        bus.En   = 1'b1;
        bus.Len  = 2'd0;
        bus.Wait = 1'b0;

        test_reset();
        test_length(2'd3);
        test_length(2'd1);
        test_len_change();
        test_wait();
        test_watchdog();
        test_en_freeze();
        test_async_reset();

        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
